// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and requester encodings for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int   RF_DATA_W = 32;
    localparam int   RF_ADDR_W = 5;

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin grant between the ALU and load unit, remembering the last winner.
import regfile_wb_arbiter_pkg::*;

module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    logic last_grant_r;
    logic gnt_alu_s;
    logic gnt_mem_s;

    // Grant decode: a lone requester wins; a tie goes to whoever did not win last.
    always_comb begin
        gnt_alu_s = 1'b0;
        gnt_mem_s = 1'b0;
        if (!rst || hold) begin
            gnt_alu_s = 1'b0;
            gnt_mem_s = 1'b0;
        end else begin
            case ({req_alu, req_mem})
                2'b10: gnt_alu_s = 1'b1;
                2'b01: gnt_mem_s = 1'b1;
                2'b11: begin
                    if (last_grant_r == GRANT_ALU) begin
                        gnt_mem_s = 1'b1;
                    end else begin
                        gnt_alu_s = 1'b1;
                    end
                end
                default: begin
                    gnt_alu_s = 1'b0;
                    gnt_mem_s = 1'b0;
                end
            endcase
        end
    end

    // Last-winner state only moves when a grant actually transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= GRANT_ALU;
        end else if (gnt_alu_s) begin
            last_grant_r <= GRANT_ALU;
        end else if (gnt_mem_s) begin
            last_grant_r <= GRANT_MEM;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign gnt_alu = gnt_alu_s;
    assign gnt_mem = gnt_mem_s;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and load unit, one registered write per cycle.
// Optional write-to-read forwarding is enabled by defining RF_WB_FWD_EN.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_hold,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data
`ifdef RF_WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] read_addr_0,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic              fwd_hit_0,
    output logic              fwd_hit_1,
    output logic [DATA_W-1:0] fwd_data_0,
    output logic [DATA_W-1:0] fwd_data_1
`endif
);

    logic              gnt_alu_s;
    logic              gnt_mem_s;
    logic              xfer_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              write_en_r;
    logic [ADDR_W-1:0] write_addr_r;
    logic [DATA_W-1:0] write_data_r;

    // Register 0 is hardwired; transfers aimed at it are consumed without a write.
    function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
        return (addr != {ADDR_W{1'b0}});
    endfunction

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .hold    (wb_hold),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu_s),
        .gnt_mem (gnt_mem_s)
    );

    assign alu_ready = gnt_alu_s;
    assign mem_ready = gnt_mem_s;
    assign xfer_s    = gnt_alu_s | gnt_mem_s;

    // Steer the winning requester's payload to the output stage.
    always_comb begin
        sel_addr_s = alu_addr;
        sel_data_s = alu_data;
        if (gnt_mem_s) begin
            sel_addr_s = mem_addr;
            sel_data_s = mem_data;
        end else begin
            sel_addr_s = alu_addr;
            sel_data_s = alu_data;
        end
    end

    // Output stage: one-cycle write pulse; address and data hold between transfers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_en_r   <= 1'b0;
            write_addr_r <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
        end else if (xfer_s) begin
            write_en_r   <= addr_writable(sel_addr_s);
            write_addr_r <= sel_addr_s;
            write_data_r <= sel_data_s;
        end else begin
            write_en_r   <= 1'b0;
            write_addr_r <= write_addr_r;
            write_data_r <= write_data_r;
        end
    end

    assign write_en   = write_en_r;
    assign write_addr = write_addr_r;
    assign write_data = write_data_r;

`ifdef RF_WB_FWD_EN
    // Forward the in-flight write to any read port addressing the same register.
    always_comb begin
        fwd_hit_0  = 1'b0;
        fwd_hit_1  = 1'b0;
        fwd_data_0 = {DATA_W{1'b0}};
        fwd_data_1 = {DATA_W{1'b0}};
        if (write_en_r && (write_addr_r == read_addr_0)) begin
            fwd_hit_0  = 1'b1;
            fwd_data_0 = write_data_r;
        end else begin
            fwd_hit_0  = 1'b0;
            fwd_data_0 = {DATA_W{1'b0}};
        end
        if (write_en_r && (write_addr_r == read_addr_1)) begin
            fwd_hit_1  = 1'b1;
            fwd_data_1 = write_data_r;
        end else begin
            fwd_hit_1  = 1'b0;
            fwd_data_1 = {DATA_W{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; forwarding checks compile in when RF_WB_FWD_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_hold;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
`ifdef RF_WB_FWD_EN
    logic [4:0]  read_addr_0;
    logic [4:0]  read_addr_1;
    logic        fwd_hit_0;
    logic        fwd_hit_1;
    logic [31:0] fwd_data_0;
    logic [31:0] fwd_data_1;
`endif

    int total;
    int bad;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_hold    (wb_hold),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data)
`ifdef RF_WB_FWD_EN
        ,
        .read_addr_0 (read_addr_0),
        .read_addr_1 (read_addr_1),
        .fwd_hit_0   (fwd_hit_0),
        .fwd_hit_1   (fwd_hit_1),
        .fwd_data_0  (fwd_data_0),
        .fwd_data_1  (fwd_data_1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        wb_hold   = 1'b0;
        alu_valid = 1'b1;
        alu_addr  = 5'd5;
        alu_data  = 32'hAA;
        mem_valid = 1'b0;
        mem_addr  = 5'd0;
        mem_data  = 32'h0;
`ifdef RF_WB_FWD_EN
        read_addr_0 = 5'd0;
        read_addr_1 = 5'd0;
`endif
        #2;
        // reset state and readies held low while in reset
        chk("rst_we",    32'(write_en),   32'h0);
        chk("rst_wa",    32'(write_addr), 32'h0);
        chk("rst_wd",    write_data,      32'h0);
        chk("rst_ardy",  32'(alu_ready),  32'h0);
        chk("rst_mrdy",  32'(mem_ready),  32'h0);
`ifdef RF_WB_FWD_EN
        chk("rst_fh0",   32'(fwd_hit_0),  32'h0);
`endif
        cyc();
        chk("rst_edge_we", 32'(write_en), 32'h0);

        // single ALU request
        rst = 1'b1;
        #1;
        chk("single_ardy", 32'(alu_ready), 32'h1);
        chk("single_mrdy", 32'(mem_ready), 32'h0);
        cyc();
        chk("single_we", 32'(write_en),   32'h1);
        chk("single_wa", 32'(write_addr), 32'h5);
        chk("single_wd", write_data,      32'hAA);

        // idle: pulse drops, addr/data hold
        alu_valid = 1'b0;
        #1;
        chk("idle_ardy", 32'(alu_ready), 32'h0);
        cyc();
        chk("idle_we", 32'(write_en),   32'h0);
        chk("idle_wa", 32'(write_addr), 32'h5);
        chk("idle_wd", write_data,      32'hAA);

        // both valid: MEM, ALU, MEM, ALU with one write per cycle
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h22;
        #1;
        chk("rr0_mrdy", 32'(mem_ready), 32'h1);
        chk("rr0_ardy", 32'(alu_ready), 32'h0);
        cyc();
        chk("rr0_we", 32'(write_en),   32'h1);
        chk("rr0_wa", 32'(write_addr), 32'h7);
        chk("rr0_wd", write_data,      32'h22);
        chk("rr1_ardy", 32'(alu_ready), 32'h1);
        chk("rr1_mrdy", 32'(mem_ready), 32'h0);
        cyc();
        chk("rr1_we", 32'(write_en),   32'h1);
        chk("rr1_wa", 32'(write_addr), 32'h3);
        chk("rr1_wd", write_data,      32'h11);
        chk("rr2_mrdy", 32'(mem_ready), 32'h1);
        cyc();
        chk("rr2_we", 32'(write_en),   32'h1);
        chk("rr2_wa", 32'(write_addr), 32'h7);
        chk("rr3_ardy", 32'(alu_ready), 32'h1);
        cyc();
        chk("rr3_we", 32'(write_en),   32'h1);
        chk("rr3_wa", 32'(write_addr), 32'h3);

        // hold with both valid for three cycles; last winner was ALU
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ardy", 32'(alu_ready), 32'h0);
            chk("hold_mrdy", 32'(mem_ready), 32'h0);
            cyc();
            chk("hold_we", 32'(write_en), 32'h0);
        end
        wb_hold = 1'b0;
        #1;
        chk("unhold_mrdy", 32'(mem_ready), 32'h1);
        chk("unhold_ardy", 32'(alu_ready), 32'h0);
        cyc();
        chk("unhold_wa", 32'(write_addr), 32'h7);

        // write to register 0 is consumed, no write, and counts as the last grant
        alu_valid = 1'b0;
        mem_addr  = 5'd0;
        mem_data  = 32'hFF;
        #1;
        chk("r0_mrdy", 32'(mem_ready), 32'h1);
        cyc();
        chk("r0_we", 32'(write_en), 32'h0);
        alu_valid = 1'b1;
        mem_addr  = 5'd7;
        mem_data  = 32'h22;
        #1;
        chk("r0_next_ardy", 32'(alu_ready), 32'h1);
        cyc();
        chk("r0_next_wa", 32'(write_addr), 32'h3);

        // reset mid-stream while a MEM transfer is being accepted
        chk("pre_rst_mrdy", 32'(mem_ready), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_rst_we",   32'(write_en),   32'h0);
        chk("mid_rst_wa",   32'(write_addr), 32'h0);
        chk("mid_rst_wd",   write_data,      32'h0);
        chk("mid_rst_mrdy", 32'(mem_ready),  32'h0);
        cyc();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("post_rst_we", 32'(write_en), 32'h0);
        cyc();
        chk("post_rst_we2", 32'(write_en), 32'h0);
        chk("post_rst_wa",  32'(write_addr), 32'h0);

        // tie right after reset goes to MEM
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #1;
        chk("post_rst_tie", 32'(mem_ready), 32'h1);
        alu_valid = 1'b0;
        mem_valid = 1'b0;

`ifdef RF_WB_FWD_EN
        // forwarding of the in-flight write
        cyc();
        alu_valid   = 1'b1;
        alu_addr    = 5'd9;
        alu_data    = 32'h1234;
        read_addr_0 = 5'd9;
        read_addr_1 = 5'd8;
        cyc();
        alu_valid = 1'b0;
        #1;
        chk("fwd_hit0",  32'(fwd_hit_0), 32'h1);
        chk("fwd_data0", fwd_data_0,     32'h1234);
        chk("fwd_hit1",  32'(fwd_hit_1), 32'h0);
        chk("fwd_data1", fwd_data_1,     32'h0);
        cyc();
        chk("fwd_stale", 32'(fwd_hit_0), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
